uart_sample_assembler: RTL and testbench
========================================

# uart_sample_assembler

Sits directly downstream of the UART receiver and upstream of the FIR filter. Packs consecutive received bytes, little-endian, into SAMPLE_BYTES-wide samples. Buffers them in a small first-word-fall-through FIFO and presents them to the filter over a valid/ready handshake. Optionally discards partial samples after an inter-byte timeout so a lost byte cannot permanently misalign the byte stream.

## Interface
- SAMPLE_BYTES, 2, bytes per sample (1..4); SAMPLE_W = 8*SAMPLE_BYTES.
- FIFO_DEPTH, 4, sample slots in output FIFO (power of two, ≥2).
- TIMEOUT_CYCLES, 8680, clk cycles allowed between bytes of one sample (2 byte-times at 50 MHz/115200).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- RxD_data  input  8  received byte; valid only while RxD_data_ready=1.
- RxD_data_ready  input  1  single-cycle strobe, one per received byte.
- sample_data  output  SAMPLE_W  FIFO head sample.
- sample_valid  output  1  FIFO non-empty.
- sample_ready  input  1  filter accepts head this cycle.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied slots.
- overflow  output  1  sticky: a completed sample was dropped (FIFO full).
- frame_err  output  1  sticky: a partial sample was discarded by timeout.

## Operation
- Assembler: byte index byte_idx (0..SAMPLE_BYTES-1) and shift register asm_reg.
- On RxD_data_ready, RxD_data is written to asm_reg[8*byte_idx +: 8]. First byte is least significant. No sign handling.
- If byte_idx < SAMPLE_BYTES-1: byte_idx increments.
- Else: byte_idx returns to 0, and {RxD_data, lower asm_reg bytes} is pushed into the FIFO.
- Push when the FIFO is full: dropped unless a pop occurs in the same cycle. A dropped push sets overflow.
- A push with a simultaneous pop on a full FIFO is accepted; fifo_count stays unchanged.
- Pop occurs when sample_valid && sample_ready. Holding sample_ready with an empty FIFO has no effect.
- FIFO is first-word-fall-through: sample_data is the oldest entry whenever sample_valid=1. sample_data is 0 while empty.
- Read/write pointers wrap modulo FIFO_DEPTH. Full is fifo_count==FIFO_DEPTH.
- overflow and frame_err clear only on rst.
- SAMPLE_BYTES=1: every byte pushes directly. The timeout never fires.

## Timing
- Reset values: byte_idx=0, asm_reg=0, FIFO empty, sample_valid=0, sample_data=0, fifo_count=0, overflow=0, frame_err=0.
- Latency: final-byte strobe in cycle N → sample_valid=1 and sample_data updated in cycle N+1.
- Pop in cycle N → head advances and fifo_count decrements in cycle N+1.
- Back-to-back strobes on consecutive cycles are supported. One byte is accepted per strobe and nothing is lost.
- rst mid-sample or with a non-empty FIFO: all state returns to reset values immediately. Partial bytes are discarded.

## Configuration
- ASM_TIMEOUT_EN defined:
  - A timeout counter clears on every RxD_data_ready and counts while byte_idx≠0.
  - When it reaches TIMEOUT_CYCLES-1: byte_idx←0, asm_reg←0, frame_err←1, counter←0.
  - If a strobe arrives in the timeout cycle, the strobe wins. The byte is taken as a continuation and no timeout occurs.
- ASM_TIMEOUT_EN undefined: no counter. frame_err is tied 0. Partial samples wait indefinitely.

## Structure
- Shared package uart_fir_pkg holds:
  - the SAMPLE_W derivation function and byte-index width constant;
  - the default TIMEOUT_CYCLES, computed from ClkFrequency/Baud the same way as the UART blocks.
- One sub-module, sample_fifo: parameterised width/depth FWFT FIFO with push, pop, count and full/empty. The assembler, timeout and sticky flags stay in the top.

## Test plan
- Bytes 0x34 then 0x12, strobes 10 cycles apart → one cycle after the second strobe, sample_valid=1, sample_data=0x1234, fifo_count=1.
- sample_ready held 0, 5 complete samples (0x0001..0x0005), FIFO_DEPTH=4 → fifo_count=4, overflow=1. Draining yields 0x0001..0x0004 only.
- FIFO full, final-byte strobe in the same cycle as sample_ready=1 → count stays 4, new sample is accepted, overflow stays 0.
- ASM_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - send 0xAA, wait 20 cycles → frame_err=1, no sample;
  - then send 0x78, 0x56 → sample_data=0x5678.
- rst pulsed after one byte of a sample, then 0xCD, 0xAB sent → sample_data=0xABCD, all flags 0.
- Back-to-back strobes every cycle for 8 bytes 0x01..0x08, sample_ready=1 → samples 0x0201, 0x0403, 0x0605, 0x0807 in order, no overflow.

Source files
------------

// File: rtl/uart_fir_pkg.sv
// Shared constants and helpers for the UART -> FIR sample path.
// Latency: none (package only).
// Backpressure: n/a.
package uart_fir_pkg;

    // Same clock/baud pair the UART receiver and transmitter are built for.
    localparam int ClkFrequency = 50_000_000;
    localparam int Baud         = 115200;

    // Two 10-bit byte-times (start + 8 data + stop) expressed in clk cycles.
    localparam int TIMEOUT_CYCLES_DEF = (20 * ClkFrequency) / Baud;

    // Wide enough to index up to four bytes of a sample.
    localparam int BYTE_IDX_W = 2;

    // Sample width in bits for a given number of bytes per sample.
    function automatic int sample_w(input int sample_bytes);
        return 8 * sample_bytes;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO holding assembled samples.
// Latency: push in cycle N visible at o_dat/o_vld in cycle N+1; pop advances head in N+1.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dat,
    output logic                       o_vld,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_vld   = !w_empty;
    assign o_dat   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array; contents are don't-care until written, output is masked when empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_sample_assembler.sv
// Packs UART bytes little-endian into samples and queues them for the FIR filter.
// Latency: final-byte strobe in cycle N -> sample_valid/sample_data in cycle N+1.
// Backpressure: valid/ready to filter; completed samples dropped (sticky overflow) when FIFO full.
// Optional ASM_TIMEOUT_EN: discard a partial sample after TIMEOUT_CYCLES idle (sticky frame_err).
module uart_sample_assembler
    import uart_fir_pkg::*;
#(
    parameter int SAMPLE_BYTES   = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          RxD_data,
    input  logic                                RxD_data_ready,
    output logic [sample_w(SAMPLE_BYTES)-1:0]   sample_data,
    output logic                                sample_valid,
    input  logic                                sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
    output logic                                overflow,
    output logic                                frame_err
);

    localparam int SAMPLE_W = sample_w(SAMPLE_BYTES);

    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic [SAMPLE_W-1:0]   r_asm;
    logic                  r_overflow;

    logic                  w_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic [SAMPLE_W-1:0]   w_push_dat;

    assign w_last = (r_byte_idx == BYTE_IDX_W'(SAMPLE_BYTES - 1));
    assign w_push = RxD_data_ready && w_last;
    assign w_pop  = sample_valid && sample_ready;

    // Completed sample: the incoming byte becomes the most significant byte.
    always_comb begin
        w_push_dat                 = r_asm;
        w_push_dat[SAMPLE_W-1 -: 8] = RxD_data;
    end

`ifdef ASM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_frame_err;

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    // Byte assembler; a strobe always takes priority over the idle timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx  <= '0;
            r_asm       <= '0;
`ifdef ASM_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
`endif
        end else if (RxD_data_ready) begin
            for (int b = 0; b < SAMPLE_BYTES; b++) begin
                if (r_byte_idx == BYTE_IDX_W'(b)) begin
                    r_asm[8*b +: 8] <= RxD_data;
                end
            end
            r_byte_idx <= w_last ? '0 : r_byte_idx + 1'b1;
`ifdef ASM_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end
`ifdef ASM_TIMEOUT_EN
        else if (r_byte_idx != '0) begin
            if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                r_byte_idx  <= '0;
                r_asm       <= '0;
                r_frame_err <= 1'b1;
                r_to_cnt    <= '0;
            end else begin
                r_to_cnt    <= r_to_cnt + 1'b1;
            end
        end
`endif
    end

    // Sticky record of any completed sample lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_dat      (sample_data),
        .o_vld      (sample_valid),
        .o_full     (w_full),
        .o_count    (fifo_count)
    );

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Scoreboard bench for uart_sample_assembler (SAMPLE_BYTES=2, FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
// Stimulus updates a byte-queue reference model; a negedge monitor checks DUT state and pops data.
// Builds with or without ASM_TIMEOUT_EN; expectations follow the macro.
module tb_uart_sample_assembler;

    localparam int SB    = 2;
    localparam int DEPTH = 4;
    localparam int T     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  RxD_data = 8'h00;
    logic        RxD_data_ready = 1'b0;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        frame_err;

    uart_sample_assembler #(
        .SAMPLE_BYTES   (SB),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0]  m_part[$];
    logic [15:0] exp_q[$];
    int          m_cnt  = 0;
    int          m_gap  = 0;
    logic        m_ovf  = 1'b0;
    logic        m_ferr = 1'b0;

    // Snapshot of the model state the DUT should show at the coming negedge
    int          s_cnt  = 0;
    logic        s_ovf  = 1'b0;
    logic        s_ferr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs for the next rising edge and advance the model.
    task automatic step(input logic stb, input logic [7:0] b, input logic rdy);
        logic        pop;
        logic        push;
        logic        acc;
        logic [15:0] s;
        @(posedge clk);
        #2;
        s_cnt  = m_cnt;
        s_ovf  = m_ovf;
        s_ferr = m_ferr;
        RxD_data_ready = stb;
        RxD_data       = b;
        sample_ready   = rdy;
        pop  = rdy && (m_cnt != 0);
        push = 1'b0;
        s    = 16'h0000;
        if (stb) begin
            m_gap = 0;
            m_part.push_back(b);
            if (m_part.size() == SB) begin
                for (int i = 0; i < SB; i++) s = s | (16'(m_part[i]) << (8 * i));
                m_part.delete();
                push = 1'b1;
            end
        end else if (m_part.size() != 0) begin
            m_gap++;
`ifdef ASM_TIMEOUT_EN
            if (m_gap == T) begin
                m_part.delete();
                m_ferr = 1'b1;
                m_gap  = 0;
            end
`endif
        end
        acc = (m_cnt < DEPTH) || pop;
        if (pop) m_cnt--;
        if (push) begin
            if (acc) begin
                exp_q.push_back(s);
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        RxD_data_ready = 1'b0;
        sample_ready   = 1'b0;
        m_part.delete();
        exp_q.delete();
        m_cnt = 0; m_gap = 0; m_ovf = 1'b0; m_ferr = 1'b0;
        s_cnt = 0; s_ovf = 1'b0; s_ferr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] v, input logic rdy);
        step(1'b1, v[7:0], rdy);
        step(1'b1, v[15:8], rdy);
    endtask

    // Monitor: compare state against snapshot, compare/pop head on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("fifo_count", 32'(fifo_count), 32'(s_cnt));
                chk("sample_valid", 32'(sample_valid), 32'(s_cnt != 0));
                chk("overflow", 32'(overflow), 32'(s_ovf));
                chk("frame_err", 32'(frame_err), 32'(s_ferr));
                if (s_cnt != 0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL scoreboard_underrun: DUT valid with data 0x%0h, nothing expected", sample_data);
                    end else begin
                        chk("sample_data", 32'(sample_data), 32'(exp_q[0]));
                        if (sample_valid && sample_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("empty_data", 32'(sample_data), 32'h0);
                end
            end
        end
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_data", 32'(sample_data), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);

        // Two bytes 10 cycles apart
        step(1'b1, 8'h34, 1'b0);
        repeat (9) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("pair_data", 32'(sample_data), 32'h1234);
        chk("pair_count", 32'(fifo_count), 32'd1);

        // Overflow: five samples into four slots, then drain
        do_reset();
        for (int i = 1; i <= 5; i++) send_sample(16'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        repeat (6) step(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("ovf_drained", 32'(fifo_count), 32'd0);

        // Full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 1; i <= 4; i++) send_sample(16'(16'h0100 + i), 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("full_pp_count", 32'(fifo_count), 32'd4);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        repeat (6) step(1'b0, 8'h00, 1'b1);

        // Idle gap after a single byte
        do_reset();
        step(1'b1, 8'hAA, 1'b0);
        repeat (20) step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("gap_count", 32'(fifo_count), 32'd0);
`ifdef ASM_TIMEOUT_EN
        chk("gap_frame_err", 32'(frame_err), 32'd1);
`else
        chk("gap_frame_err", 32'(frame_err), 32'd0);
`endif
        step(1'b1, 8'h78, 1'b0);
        step(1'b1, 8'h56, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
`ifdef ASM_TIMEOUT_EN
        chk("gap_data", 32'(sample_data), 32'h5678);
`else
        chk("gap_data", 32'(sample_data), 32'h78AA);
`endif
        repeat (4) step(1'b0, 8'h00, 1'b1);

        // Reset mid-sample
        do_reset();
        step(1'b1, 8'hEF, 1'b0);
        do_reset();
        step(1'b1, 8'hCD, 1'b0);
        step(1'b1, 8'hAB, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("rstmid_data", 32'(sample_data), 32'hABCD);
        chk("rstmid_flags", 32'({overflow, frame_err}), 32'h0);

        // Back-to-back strobes with ready held
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("b2b_ovf", 32'(overflow), 32'd0);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with bursts of backpressure and occasional long gaps
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                repeat (T + 2) step(1'b0, 8'($urandom), 1'b1);
            end else begin
                step($urandom_range(0, 9) < 4, 8'($urandom),
                     ((i / 60) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0));
            end
        end
        repeat (8) step(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
